// File: rtl/spmv_out_pkg.sv
//------------------------------------------------------------------------------
// Package : spmv_out_pkg
// Purpose : Shared word layout and build constants for the merge-unit output
//           sink. Output words are {row_idx, value, valid}. row_idx sits in
//           the top bits and the valid flag is bit 0.
// Build macros (defaults are applied when not set by the build):
//   DATA_WIDTH_ADD_STG        word width of the add stage (default 32)
//   NUM_OUTPUT_WORDS_PER_UNIT words per unit bank         (default 8)
//   BITS_ROW_IDX              row index width             (default 12)
//   MODE_WORK                 mode value that enables writes (default 1'b1)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef DATA_WIDTH_ADD_STG
`define DATA_WIDTH_ADD_STG 32
`endif
`ifndef NUM_OUTPUT_WORDS_PER_UNIT
`define NUM_OUTPUT_WORDS_PER_UNIT 8
`endif
`ifndef BITS_ROW_IDX
`define BITS_ROW_IDX 12
`endif
`ifndef MODE_WORK
`define MODE_WORK 1'b1
`endif

package spmv_out_pkg;

    localparam int   OUT_DATA_WIDTH = `DATA_WIDTH_ADD_STG;
    localparam int   OUT_DEPTH      = `NUM_OUTPUT_WORDS_PER_UNIT;
    localparam int   BITS_ROW_IDX   = `BITS_ROW_IDX;
    localparam logic MODE_WORK      = `MODE_WORK;

    // Field offsets inside an output word
    localparam int VALID_BIT = 0;
    localparam int VAL_LSB   = 1;
    localparam int ROW_LSB   = OUT_DATA_WIDTH - BITS_ROW_IDX;

    typedef logic [OUT_DATA_WIDTH-1:0] out_word_t;

    function automatic logic [BITS_ROW_IDX-1:0] row_of(input out_word_t w);
        return w[ROW_LSB +: BITS_ROW_IDX];
    endfunction

endpackage

`default_nettype wire

// File: rtl/out_unit_bank.sv
//------------------------------------------------------------------------------
// Module  : out_unit_bank
// Purpose : Storage bank for one merge unit. Valid, non-sentinel words are
//           appended at the write pointer until the bank is full. Words that
//           arrive while the bank is full are refused and counted in a
//           saturating drop counter. Reads are asynchronous. The parent
//           registers the read data.
// Ports   : clk, rst_b (async, active-low), clear (sync flush),
//           wr_en    - unit enabled and the block is in work mode
//           din      - incoming word
//           full     - bank holds DEPTH words
//           count    - words stored (0..DEPTH)
//           drops    - refused-word counter (saturating)
//           order_err- sticky row-order error
//           rd_addr / rd_data - asynchronous read port
// Option  : OUT_ROW_ORDER_CHECK_EN enables the row-order check. When it is
//           not defined, order_err is tied 0.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module out_unit_bank
    import spmv_out_pkg::*;
#(
    parameter int DATA_WIDTH = OUT_DATA_WIDTH,
    parameter int DEPTH      = OUT_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int DROP_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic [ADDR_W:0]       count,
    output logic [DROP_W-1:0]     drops,
    output logic                  order_err,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_W:0]         wr_ptr;
    logic [DROP_W-1:0]       drop_q;
    logic [BITS_ROW_IDX-1:0] row;
    logic                    candidate;
    logic                    accept;
    logic                    refuse;

    assign row       = row_of(din);
    // Only valid, non-sentinel words count as candidates.
    assign candidate = wr_en && din[VALID_BIT] && (row != '0);
    assign full      = (wr_ptr == FULL_COUNT);
    assign accept    = candidate && !full;
    assign refuse    = candidate && full;

    assign count   = wr_ptr;
    assign drops   = drop_q;
    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            drop_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            drop_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem[wr_ptr[ADDR_W-1:0]] <= din;
                wr_ptr                  <= wr_ptr + 1'b1;
            end
            if (refuse && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

`ifdef OUT_ROW_ORDER_CHECK_EN
    logic [BITS_ROW_IDX-1:0] last_row;
    logic                    have_row;   // first accepted word since reset/clear has no predecessor
    logic                    err_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last_row <= '0;
            have_row <= 1'b0;
            err_q    <= 1'b0;
        end else if (clear) begin
            last_row <= '0;
            have_row <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            if (have_row && (row <= last_row)) begin
                err_q <= 1'b1;
            end
            last_row <= row;
            have_row <= 1'b1;
        end
    end

    assign order_err = err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/multi_unit_output_collect.sv
//------------------------------------------------------------------------------
// Module  : multi_unit_output_collect
// Purpose : Output sink for NUM_UNITS merge units. Each unit has its own bank
//           (out_unit_bank), with its own pointer, full flag and drop counter.
//           The banks share one registered read port.
// Ports   : clk, rst_b (async, active-low), mode, clear, unit_en, data_in
//           (unit u at [u*DATA_WIDTH +: DATA_WIDTH]), unit_full, wr_count,
//           drop_cnt, rd_req, rd_unit, rd_addr, rd_valid, rd_data, order_err.
// Option  : OUT_ROW_ORDER_CHECK_EN enables the sticky per-unit row-order
//           check. When it is not defined, order_err is tied 0.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multi_unit_output_collect
    import spmv_out_pkg::*;
#(
    parameter int NUM_UNITS  = 4,
    parameter int DATA_WIDTH = OUT_DATA_WIDTH,
    parameter int DEPTH      = OUT_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int DROP_W     = 8,
    parameter int UNIT_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_b,
    input  logic                            mode,
    input  logic                            clear,
    input  logic [NUM_UNITS-1:0]            unit_en,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_UNITS-1:0]            unit_full,
    output logic [NUM_UNITS*(ADDR_W+1)-1:0] wr_count,
    output logic [NUM_UNITS*DROP_W-1:0]     drop_cnt,
    input  logic                            rd_req,
    input  logic [UNIT_W-1:0]               rd_unit,
    input  logic [ADDR_W-1:0]               rd_addr,
    output logic                            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [NUM_UNITS-1:0]            order_err
);

    logic [DATA_WIDTH-1:0] bank_rd [NUM_UNITS];
    logic                  work_mode;

    assign work_mode = (mode == MODE_WORK);

    generate
        for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
            out_unit_bank #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH),
                .ADDR_W     (ADDR_W),
                .DROP_W     (DROP_W)
            ) u_bank (
                .clk       (clk),
                .rst_b     (rst_b),
                .clear     (clear),
                .wr_en     (work_mode && unit_en[u]),
                .din       (data_in[u*DATA_WIDTH +: DATA_WIDTH]),
                .full      (unit_full[u]),
                .count     (wr_count[u*(ADDR_W+1) +: (ADDR_W+1)]),
                .drops     (drop_cnt[u*DROP_W +: DROP_W]),
                .order_err (order_err[u]),
                .rd_addr   (rd_addr),
                .rd_data   (bank_rd[u])
            );
        end
    endgenerate

    // The read samples the bank before this edge's write or clear lands, so a
    // same-cycle write or clear is not visible to the read.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= bank_rd[rd_unit];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_unit_output_collect.sv
//------------------------------------------------------------------------------
// Module  : tb_multi_unit_output_collect
// Purpose : Self-checking bench for multi_unit_output_collect. A per-unit
//           list model (stored words, count, drops, order flag) predicts every
//           output after each clock edge. Directed scenarios are followed by
//           randomized traffic.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multi_unit_output_collect;
    import spmv_out_pkg::*;

    localparam int NU     = 4;
    localparam int DW     = OUT_DATA_WIDTH;
    localparam int DEPTH  = OUT_DEPTH;
    localparam int AW     = $clog2(DEPTH);
    localparam int DROP_W = 8;
    localparam int UW     = 2;
    localparam int VW     = ROW_LSB - VAL_LSB;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_b;
    logic                  mode;
    logic                  clear;
    logic [NU-1:0]         unit_en;
    logic [NU*DW-1:0]      data_in;
    logic [NU-1:0]         unit_full;
    logic [NU*(AW+1)-1:0]  wr_count;
    logic [NU*DROP_W-1:0]  drop_cnt;
    logic                  rd_req;
    logic [UW-1:0]         rd_unit;
    logic [AW-1:0]         rd_addr;
    logic                  rd_valid;
    logic [DW-1:0]         rd_data;
    logic [NU-1:0]         order_err;

    multi_unit_output_collect #(
        .NUM_UNITS (NU),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_W    (AW),
        .DROP_W    (DROP_W),
        .UNIT_W    (UW)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .mode      (mode),
        .clear     (clear),
        .unit_en   (unit_en),
        .data_in   (data_in),
        .unit_full (unit_full),
        .wr_count  (wr_count),
        .drop_cnt  (drop_cnt),
        .rd_req    (rd_req),
        .rd_unit   (rd_unit),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .order_err (order_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [NU][DEPTH];
    int            m_cnt  [NU];
    int            m_drop [NU];
    bit            m_err  [NU];
    int            m_last [NU];
    bit            m_have [NU];
    logic [DW-1:0] m_rd;
    bit            m_rv;

    task automatic model_flush();
        for (int u = 0; u < NU; u++) begin
            for (int a = 0; a < DEPTH; a++) m_mem[u][a] = '0;
            m_cnt[u] = 0; m_drop[u] = 0; m_err[u] = 0; m_last[u] = 0; m_have[u] = 0;
        end
    endtask

    task automatic model_reset();
        model_flush();
        m_rd = '0;
        m_rv = 0;
    endtask

    // Applies the currently driven inputs to the model as one clock edge.
    task automatic model_edge();
        logic [DW-1:0] w;
        int            row;
        if (rd_req) begin
            m_rd = m_mem[rd_unit][rd_addr];
            m_rv = 1;
        end else begin
            m_rv = 0;
        end
        if (clear) begin
            model_flush();
        end else begin
            for (int u = 0; u < NU; u++) begin
                w   = data_in[u*DW +: DW];
                row = int'(row_of(w));
                if (mode == MODE_WORK && unit_en[u] && w[0] && row != 0) begin
                    if (m_cnt[u] < DEPTH) begin
                        if (m_have[u] && row <= m_last[u]) m_err[u] = 1;
                        m_last[u] = row;
                        m_have[u] = 1;
                        m_mem[u][m_cnt[u]] = w;
                        m_cnt[u]++;
                    end else if (m_drop[u] < DROP_MAX) begin
                        m_drop[u]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        bit exp_err;
        for (int u = 0; u < NU; u++) begin
`ifdef OUT_ROW_ORDER_CHECK_EN
            exp_err = m_err[u];
`else
            exp_err = 0;
`endif
            check_val($sformatf("%s wr_count[%0d]", tag, u), 64'(wr_count[u*(AW+1) +: (AW+1)]), 64'(m_cnt[u]));
            check_val($sformatf("%s unit_full[%0d]", tag, u), 64'(unit_full[u]), 64'(m_cnt[u] == DEPTH));
            check_val($sformatf("%s drop_cnt[%0d]", tag, u), 64'(drop_cnt[u*DROP_W +: DROP_W]), 64'(m_drop[u]));
            check_val($sformatf("%s order_err[%0d]", tag, u), 64'(order_err[u]), 64'(exp_err));
        end
        check_val($sformatf("%s rd_valid", tag), 64'(rd_valid), 64'(m_rv));
        check_val($sformatf("%s rd_data", tag), 64'(rd_data), 64'(m_rd));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        mode    = MODE_WORK;
        clear   = 1'b0;
        unit_en = '0;
        data_in = '0;
        rd_req  = 1'b0;
        rd_unit = '0;
        rd_addr = '0;
    endtask

    function automatic logic [DW-1:0] mk(input int row, input bit valid);
        logic [DW-1:0] w = '0;
        w[ROW_LSB +: BITS_ROW_IDX] = BITS_ROW_IDX'(row);
        w[VAL_LSB +: VW]           = VW'($urandom);
        w[VALID_BIT]               = valid;
        return w;
    endfunction

    task automatic put(input int u, input logic [DW-1:0] w);
        unit_en[u]          = 1'b1;
        data_in[u*DW +: DW] = w;
    endtask

    task automatic rd(input int u, input int a);
        rd_req  = 1'b1;
        rd_unit = UW'(u);
        rd_addr = AW'(a);
    endtask

    // One clock edge with the inputs currently driven, then compare everything.
    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        idle();
        check_all(tag);
    endtask

    initial begin
        idle();
        rst_b = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_b = 1'b1;

        // 1: unit0 rows 5,6,7, then read address 1
        for (int r = 5; r <= 7; r++) begin
            put(0, mk(r, 1'b1));
            cycle("t1 wr");
        end
        rd(0, 1);
        cycle("t1 rd");
        check_val("t1 row", 64'(row_of(rd_data)), 64'd6);

        // 2: sentinel then invalid word on unit1
        put(1, mk(0, 1'b1));
        cycle("t2 sentinel");
        put(1, mk(3, 1'b0));
        cycle("t2 invalid");

        // 3: DEPTH+3 valid words into unit2; last slot holds word DEPTH
        for (int i = 1; i <= DEPTH + 3; i++) begin
            put(2, mk(i, 1'b1));
            cycle("t3 fill");
        end
        check_val("t3 drop_cnt[2]", 64'(drop_cnt[2*DROP_W +: DROP_W]), 64'd3);
        rd(2, DEPTH - 1);
        cycle("t3 rd");
        check_val("t3 last row", 64'(row_of(rd_data)), 64'(DEPTH));

        // 4: all units write outside work mode, then in work mode
        clear = 1'b1;
        cycle("t4 clear");
        mode = ~MODE_WORK;
        for (int u = 0; u < NU; u++) put(u, mk(u + 1, 1'b1));
        cycle("t4 idle mode");
        for (int u = 0; u < NU; u++) put(u, mk(u + 1, 1'b1));
        cycle("t4 work mode");

        // 5: clear with a same-cycle write and read on unit0
        put(0, mk(20, 1'b1));
        clear = 1'b1;
        rd(0, 0);
        cycle("t5 clear+wr");
        rd(0, 0);
        cycle("t5 rd after clear");
        check_val("t5 rd zero", 64'(rd_data), 64'd0);

        // 5b: reset asserted in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            for (int u = 0; u < NU; u++) put(u, mk(i + 1, 1'b1));
            cycle("t5 burst");
        end
        for (int u = 0; u < NU; u++) put(u, mk(9, 1'b1));
        rd(1, 0);
        #2;
        rst_b = 1'b0;
        #1;
        model_reset();
        check_all("t5 async rst");
        @(posedge clk);
        #1;
        check_all("t5 rst held");
        rst_b = 1'b1;
        idle();

        // 6: order check on unit3, rows 9 then 4
        put(3, mk(9, 1'b1));
        cycle("t6 row9");
        put(3, mk(4, 1'b1));
        cycle("t6 row4");
`ifdef OUT_ROW_ORDER_CHECK_EN
        check_val("t6 order_err[3]", 64'(order_err[3]), 64'd1);
`else
        check_val("t6 order_err[3]", 64'(order_err[3]), 64'd0);
`endif
        rd(3, 1);
        cycle("t6 rd");
        check_val("t6 stored row", 64'(row_of(rd_data)), 64'd4);
        clear = 1'b1;
        cycle("t6 clear");
        check_val("t6 order_err cleared", 64'(order_err[3]), 64'd0);

        // drop counter saturation on unit1
        for (int i = 0; i < DEPTH + DROP_MAX + 5; i++) begin
            put(1, mk(i + 1, 1'b1));
            cycle("sat");
        end
        check_val("sat drop_cnt[1]", 64'(drop_cnt[1*DROP_W +: DROP_W]), 64'(DROP_MAX));

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            mode  = ($urandom_range(0, 9) == 0) ? ~MODE_WORK : MODE_WORK;
            clear = ($urandom_range(0, 39) == 0);
            for (int u = 0; u < NU; u++) begin
                if ($urandom_range(0, 1) == 1) begin
                    put(u, mk(int'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0)));
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                rd(int'($urandom_range(0, NU - 1)), int'($urandom_range(0, DEPTH - 1)));
            end
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
